// File: rtl/rst_seq_pkg.sv
// Shared constants for the reset sequencer: state encoding and counter width.
package rst_seq_pkg;

    localparam int CNT_W = 8;

    typedef logic [2:0] state_t;

    localparam state_t RST  = 3'd0;
    localparam state_t SEQ  = 3'd1;
    localparam state_t DONE = 3'd2;
    localparam state_t SWH  = 3'd3;
    localparam state_t SWA  = 3'd4;

endpackage

// File: rtl/rst_sync2.sv
// Two-flop reset synchronizer: asserts asynchronously, deasserts two clk edges
// after rst_async goes high.
module rst_sync2 (
    input  logic clk,
    input  logic rst_async,
    output logic rst_s
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], 1'b1};
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign rst_s = sync_q[1];

endmodule

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: releases N_DOM active-low domain resets in order after
// power-on or a software reset handshake.
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int N_DOM    = 3,
    parameter int HOLD_CYC = 16,
    parameter int SW_HOLD  = 8
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             sw_rst_req,
    output logic             sw_rst_ack,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             seq_done
);

    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] SW_TC   = CNT_W'(SW_HOLD - 1);

    logic rst_s;

    rst_sync2 u_rst_sync2 (
        .clk       (clk),
        .rst_async (rst_async),
        .rst_s     (rst_s)
    );

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_DOM-1:0]   dom_q, dom_d;
    logic               done_q, done_d;
    logic               ack_q, ack_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves
        // a signal unassigned and infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        dom_d   = dom_q;
        done_d  = done_q;
        ack_d   = ack_q;

        case (state_q)
            RST: begin
                cnt_d  = '0;
                dom_d  = '0;
                done_d = 1'b0;
                ack_d  = 1'b0;
                if (rst_s) begin
                    state_d = SEQ;
                end
            end
            SEQ: begin
                if (cnt_q == HOLD_TC) begin
                    cnt_d = '0;
                    dom_d = {dom_q[N_DOM-2:0], 1'b1};
                    // The top bit is being released on this edge.
                    if (dom_q[N_DOM-2]) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (sw_rst_req) begin
                    state_d = SWH;
                    cnt_d   = '0;
                    dom_d   = '0;
                    done_d  = 1'b0;
                end
            end
            SWH: begin
                if (cnt_q == SW_TC) begin
                    state_d = SWA;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SWA: begin
                if (!sw_rst_req) begin
                    state_d = SEQ;
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                end
            end
            default: begin
                state_d = RST;
                cnt_d   = '0;
                dom_d   = '0;
                done_d  = 1'b0;
                ack_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_async) begin
        if (!rst_async) begin
            state_q <= RST;
            cnt_q   <= '0;
            dom_q   <= '0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
        end
    end

    assign dom_rst_n  = dom_q;
    assign seq_done   = done_q;
    assign sw_rst_ack = ack_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Self-checking bench for rst_seq_ctrl: main instance (3/16/8) plus two
// parameter-corner instances, compared against an edge-count reference model.
module tb_rst_seq_ctrl;

    localparam int N_A = 3;
    localparam int H_A = 16;
    localparam int SW_A = 8;
    localparam int N_B = 2;
    localparam int H_B = 1;
    localparam int N_C = 8;
    localparam int H_C = 255;

    logic clk;
    logic rst_a, req_a, rst_bc, req_b, req_c;
    logic ack_a, done_a, ack_b, done_b, ack_c, done_c;
    logic [N_A-1:0] dom_a;
    logic [N_B-1:0] dom_b;
    logic [N_C-1:0] dom_c;

    int checks = 0;
    int fails = 0;

    // Reference model state for the main instance.
    int e_a;
    int s_a;
    int r_a;
    int mode_a;
    int e_bc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    rst_seq_ctrl #(.N_DOM(N_A), .HOLD_CYC(H_A), .SW_HOLD(SW_A)) dut_a (
        .clk(clk), .rst_async(rst_a), .sw_rst_req(req_a),
        .sw_rst_ack(ack_a), .dom_rst_n(dom_a), .seq_done(done_a)
    );

    rst_seq_ctrl #(.N_DOM(N_B), .HOLD_CYC(H_B), .SW_HOLD(8)) dut_b (
        .clk(clk), .rst_async(rst_bc), .sw_rst_req(req_b),
        .sw_rst_ack(ack_b), .dom_rst_n(dom_b), .seq_done(done_b)
    );

    rst_seq_ctrl #(.N_DOM(N_C), .HOLD_CYC(H_C), .SW_HOLD(8)) dut_c (
        .clk(clk), .rst_async(rst_bc), .sw_rst_req(req_c),
        .sw_rst_ack(ack_c), .dom_rst_n(dom_c), .seq_done(done_c)
    );

    // Domains released after edge e when the sequence started at edge s.
    function automatic int released(int e, int s, int n, int h);
        int k;
        if (e < s) return 0;
        k = (e - s) / h;
        return (k > n) ? n : k;
    endfunction

    function automatic int therm(int k);
        return (1 << k) - 1;
    endfunction

    function automatic logic [N_A+1:0] exp_a();
        int k;
        logic [N_A-1:0] d;
        logic dn, ak;
        if (mode_a == 0) begin
            k  = released(e_a, s_a, N_A, H_A);
            d  = N_A'(therm(k));
            dn = (k == N_A);
            ak = 1'b0;
        end else begin
            d  = '0;
            dn = 1'b0;
            ak = (e_a >= r_a + SW_A);
        end
        return {d, dn, ak};
    endfunction

    task automatic model_a_edge(input bit rq);
        if (mode_a == 0) begin
            if (rq && released(e_a - 1, s_a, N_A, H_A) == N_A) begin
                mode_a = 1;
                r_a = e_a;
            end
        end else if ((e_a - 1 >= r_a + SW_A) && !rq) begin
            mode_a = 0;
            s_a = e_a;
        end
    endtask

    task automatic model_a_restart();
        e_a = -1;
        s_a = 2;
        r_a = -1000;
        mode_a = 0;
    endtask

    task automatic step();
        bit rq;
        rq = req_a;
        @(posedge clk);
        #1;
        e_a++;
        e_bc++;
        model_a_edge(rq);
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_bc = 1'b0;
        req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
        model_a_restart();
        repeat (5) begin
            @(posedge clk);
            #1;
            checks++;
            if ({dom_a, done_a, ack_a, dom_b, done_b, ack_b, dom_c, done_c, ack_c} !== '0) begin
                fails++;
                $display("FAIL reset_hold: a=%b b=%b c=%b, required all zero",
                         {dom_a, done_a, ack_a}, {dom_b, done_b, ack_b}, {dom_c, done_c, ack_c});
            end
        end
    endtask

    task automatic test_power_on();
        @(negedge clk);
        rst_a = 1'b1;
        model_a_restart();
        repeat (61) begin
            step();
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL power_on e=%0d: {dom,done,ack}=%b, required %b",
                         e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
    endtask

    task automatic test_sw_handshake(input int idle, input int drop, input int post);
        int n;
        repeat (idle) begin
            step();
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL sw_idle e=%0d: got %b, required %b", e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
        req_a = 1'b1;
        n = 0;
        while (!ack_a && n < SW_A + 5) begin
            step();
            n++;
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL sw_hold e=%0d: got %b, required %b", e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
        checks++;
        if (!ack_a) begin
            fails++;
            $display("FAIL sw_ack_timeout: ack=%b after %0d cycles, required 1", ack_a, n);
        end
        repeat (drop) begin
            step();
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL sw_ack e=%0d: got %b, required %b", e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
        req_a = 1'b0;
        repeat (post) begin
            step();
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL sw_rerelease e=%0d: got %b, required %b", e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
    endtask

    task automatic async_pulse(input string tag);
        #1 rst_a = 1'b0;
        #1;
        checks++;
        if ({dom_a, done_a, ack_a} !== '0) begin
            fails++;
            $display("FAIL %s: outputs=%b without clock, required 0", tag, {dom_a, done_a, ack_a});
        end
        req_a = 1'b0;
        #3 rst_a = 1'b1;
        model_a_restart();
    endtask

    task automatic test_async_mid_seq();
        async_pulse("async_mid_seq");
    endtask

    task automatic test_early_req();
        int p;
        p = $urandom_range(5, 40);
        for (int i = 0; i < 61; i++) begin
            if (i == p) req_a = 1'b1;
            if (i == p + 4) req_a = 1'b0;
            step();
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL early_req e=%0d: got %b, required %b", e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
    endtask

    task automatic test_async_in_swa();
        int n;
        req_a = 1'b1;
        n = 0;
        while (!ack_a && n < SW_A + 5) begin
            step();
            n++;
        end
        checks++;
        if (!ack_a) begin
            fails++;
            $display("FAIL swa_entry_timeout: ack=%b, required 1", ack_a);
        end
        repeat ($urandom_range(1, 4)) step();
        async_pulse("async_in_swa");
        repeat (61) begin
            step();
            checks++;
            if ({dom_a, done_a, ack_a} !== exp_a()) begin
                fails++;
                $display("FAIL repower e=%0d: got %b, required %b", e_a, {dom_a, done_a, ack_a}, exp_a());
            end
        end
    endtask

    task automatic test_corners();
        logic [N_B-1:0] xb;
        logic [N_C-1:0] xc;
        @(negedge clk);
        rst_bc = 1'b1;
        e_bc = -1;
        repeat (2050) begin
            step();
            xb = N_B'(therm(released(e_bc, 2, N_B, H_B)));
            xc = N_C'(therm(released(e_bc, 2, N_C, H_C)));
            checks++;
            if ({dom_b, done_b, ack_b} !== {xb, (xb[N_B-1] == 1'b1), 1'b0}) begin
                fails++;
                $display("FAIL corner_b e=%0d: got %b, required %b", e_bc, {dom_b, done_b, ack_b},
                         {xb, (xb[N_B-1] == 1'b1), 1'b0});
            end
            checks++;
            if ({dom_c, done_c, ack_c} !== {xc, (xc[N_C-1] == 1'b1), 1'b0}) begin
                fails++;
                $display("FAIL corner_c e=%0d: got %b, required %b", e_bc, {dom_c, done_c, ack_c},
                         {xc, (xc[N_C-1] == 1'b1), 1'b0});
            end
            checks++;
            if ((((dom_b + 1'b1) & dom_b) !== '0) || (((dom_c + 1'b1) & dom_c) !== '0)) begin
                fails++;
                $display("FAIL thermometer e=%0d: dom_b=%b dom_c=%b, required 0..01..1 form",
                         e_bc, dom_b, dom_c);
            end
        end
    endtask

    initial begin
        test_reset();
        test_power_on();
        test_sw_handshake(0, 3, N_A * H_A + 12);
        test_sw_handshake($urandom_range(0, 20), $urandom_range(0, 10), $urandom_range(20, 40));
        test_async_mid_seq();
        test_early_req();
        test_async_in_swa();
        test_corners();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
